hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core; the producer of the NoOp_i input consumed by the Control decoder.
- Detects load-use hazards between ID and ID/EX, and taken-branch flushes resolved in ID.
- Freezes the whole pipeline through a req/ack handshake with data memory, using a small FSM with a timeout.
- Keeps saturating performance counters for bubbles, flushes and memory-wait cycles.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the Control decoder.
package hazard_ctrl_pkg;

    // Memory-handshake FSM states.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Opcodes shared with the Control decoder.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until the counter is full.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and a
// whole-pipeline freeze while data memory is busy, with saturating counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             NoOp_o,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic             Flush_o,
    output logic             Hold_o,
    output logic             err_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    // Wide enough to hold the value MEM_TIMEOUT itself.
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          err, err_next;
    logic          lu;
    logic          timeout_hit;
    logic          mem_hold;

    // A load in EX writing a register that ID reads; x0 is never a real dependency.
    assign lu = idex_memread_i && (idex_rd_i != 5'd0) &&
                ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

    assign timeout_hit = (state == MEM_WAIT) && (tcnt == TW'(MEM_TIMEOUT));

    // Freeze request: a fresh unacknowledged access in RUN, or a pending one in MEM_WAIT.
    // NOTE: every always_comb assigns its outputs a default first so no latch is inferred.
    always_comb begin
        mem_hold = 1'b0;
        case (state)
            RUN:      mem_hold = mem_req_i && !mem_ack_i;
            MEM_WAIT: mem_hold = !mem_ack_i && !timeout_hit;
            default:  mem_hold = 1'b0;
        endcase
    end

    // Next-state logic for the memory handshake and its timeout watchdog.
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        err_next   = err;
        case (state)
            RUN: begin
                tcnt_next = '0;
                if (mem_req_i && !mem_ack_i) begin
                    state_next = MEM_WAIT;
                    tcnt_next  = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_next = RUN;
                    tcnt_next  = '0;
                end else if (timeout_hit) begin
                    // Abort the access; a late ack lands in RUN and is ignored.
                    state_next = RUN;
                    tcnt_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            default: begin
                state_next = RUN;
                tcnt_next  = '0;
            end
        endcase
    end

    // FSM state, timeout counter and sticky error flag.
    // NOTE: only control state is reset here; no memory arrays live in this block.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            err   <= err_next;
        end
    end

    // Pipeline control with fixed priority: hold, then load-use, then branch flush.
    // Outputs sit at their defaults while reset is asserted.
    always_comb begin
        NoOp_o    = 1'b0;
        Stall_o   = 1'b0;
        PCWrite_o = 1'b1;
        Flush_o   = 1'b0;
        Hold_o    = 1'b0;
        if (rst_i) begin
            if (mem_hold) begin
                Hold_o    = 1'b1;
                Stall_o   = 1'b1;
                PCWrite_o = 1'b0;
            end else if (lu) begin
                // Load-use wins over a taken branch: its operands are not ready yet.
                NoOp_o    = 1'b1;
                Stall_o   = 1'b1;
                PCWrite_o = 1'b0;
            end else if (branch_taken_i) begin
                Flush_o = 1'b1;
            end
        end
    end

    assign err_o = err;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (NoOp_o),
        .count (bubble_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (Flush_o),
        .count (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (Hold_o),
        .count (wait_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       ifid_rs1_i, ifid_rs2_i, idex_rd_i;
    logic             idex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
    logic             NoOp_o, Stall_o, PCWrite_o, Flush_o, Hold_o, err_o;
    logic [CNT_W-1:0] bubble_cnt_o, flush_cnt_o, wait_cnt_o;

    int errors = 0;
    int checks = 0;

    // Model state: access in flight, how many cycles it has been held, totals.
    bit m_waiting, m_err;
    int m_age, m_bub, m_fl, m_wait;
    bit e_noop, e_stall, e_pcw, e_flush, e_hold;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .NoOp_o         (NoOp_o),
        .Stall_o        (Stall_o),
        .PCWrite_o      (PCWrite_o),
        .Flush_o        (Flush_o),
        .Hold_o         (Hold_o),
        .err_o          (err_o),
        .bubble_cnt_o   (bubble_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .wait_cnt_o     (wait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_err = 0; m_age = 0;
        m_bub = 0; m_fl = 0; m_wait = 0;
    endtask

    // Expected combinational outputs for the inputs currently applied.
    task automatic model_comb();
        bit lu;
        lu = idex_memread_i && (idex_rd_i != 0) &&
             (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
        if (!m_waiting) e_hold = mem_req_i && !mem_ack_i;
        else            e_hold = !mem_ack_i && (m_age < MEM_TIMEOUT);
        e_noop = 0; e_stall = 0; e_pcw = 1; e_flush = 0;
        if (e_hold) begin
            e_stall = 1; e_pcw = 0;
        end else if (lu) begin
            e_noop = 1; e_stall = 1; e_pcw = 0;
        end else if (branch_taken_i) begin
            e_flush = 1;
        end
    endtask

    // Effect of one clock edge on the model.
    task automatic model_edge();
        m_bub  = (m_bub  + int'(e_noop)  > CMAX) ? CMAX : m_bub  + int'(e_noop);
        m_fl   = (m_fl   + int'(e_flush) > CMAX) ? CMAX : m_fl   + int'(e_flush);
        m_wait = (m_wait + int'(e_hold)  > CMAX) ? CMAX : m_wait + int'(e_hold);
        if (!m_waiting) begin
            if (e_hold) begin m_waiting = 1; m_age = 1; end
        end else if (mem_ack_i) begin
            m_waiting = 0;
        end else if (m_age == MEM_TIMEOUT) begin
            m_waiting = 0; m_err = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_comb(input string ctx);
        check({ctx, ".noop"},    NoOp_o,    e_noop);
        check({ctx, ".stall"},   Stall_o,   e_stall);
        check({ctx, ".pcwrite"}, PCWrite_o, e_pcw);
        check({ctx, ".flush"},   Flush_o,   e_flush);
        check({ctx, ".hold"},    Hold_o,    e_hold);
    endtask

    task automatic check_regs(input string ctx);
        check({ctx, ".err"},    err_o,        m_err);
        check({ctx, ".bubble"}, bubble_cnt_o, m_bub);
        check({ctx, ".flush_cnt"}, flush_cnt_o, m_fl);
        check({ctx, ".wait"},   wait_cnt_o,   m_wait);
    endtask

    task automatic drive(input int rs1, input int rs2, input bit mr, input int rd,
                         input bit br, input bit req, input bit ack);
        ifid_rs1_i     = 5'(rs1);
        ifid_rs2_i     = 5'(rs2);
        idex_memread_i = mr;
        idex_rd_i      = 5'(rd);
        branch_taken_i = br;
        mem_req_i      = req;
        mem_ack_i      = ack;
    endtask

    // Called 1 time unit after a rising edge: check outputs, clock, check registers.
    task automatic cycle(input string ctx);
        #2;
        model_comb();
        check_comb(ctx);
        @(posedge clk_i);
        #1;
        model_edge();
        check_regs(ctx);
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        model_comb();
        check_comb("reset");
        check_regs("reset");
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Load-use on rs2: bubble inserted in the same cycle.
        drive(1, 5, 1, 5, 0, 0, 0);
        cycle("lu_rs2");
        check("lu_rs2.bubble_is_1", bubble_cnt_o, 1);

        // rd = x0 and a non-matching rd never stall.
        drive(0, 2, 1, 0, 0, 0, 0);
        cycle("lu_x0");
        drive(3, 4, 1, 7, 0, 0, 0);
        cycle("lu_nomatch");

        // Load-use beats a branch; the flush follows once the hazard clears.
        drive(1, 5, 1, 5, 1, 0, 0);
        cycle("br_vs_lu");
        drive(1, 5, 0, 5, 1, 0, 0);
        cycle("br_flush");
        check("br_flush.count_is_1", flush_cnt_o, 1);

        // Memory wait of three cycles with a pending load-use masked by the hold.
        for (int i = 0; i < 3; i++) begin
            drive(5, 0, 1, 5, 0, 1, 0);
            cycle("memwait");
        end
        drive(5, 0, 1, 5, 0, 1, 1);
        cycle("memwait_ack");
        check("memwait.wait_is_3", wait_cnt_o, 3);

        // Timeout: four held cycles, then release with a sticky error.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            cycle("timeout_hold");
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        cycle("timeout_hit");
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle("after_timeout_idle");
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle("late_ack");
        check("timeout.err_sticky", err_o, 1);

        // Random traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 3), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
            cycle("random");
        end

        // Asynchronous reset in the middle of a wait.
        drive(0, 0, 0, 0, 0, 1, 0);
        cycle("pre_reset_req");
        drive(0, 0, 0, 0, 0, 1, 0);
        cycle("pre_reset_wait");
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst.hold",   Hold_o,       0);
        check("async_rst.err",    err_o,        0);
        check("async_rst.bubble", bubble_cnt_o, 0);
        check("async_rst.flush",  flush_cnt_o,  0);
        check("async_rst.wait",   wait_cnt_o,   0);
        model_reset();
        @(posedge clk_i);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle("post_reset_no_ack");

        // Saturation: twenty bubbles into a four-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive(9, 1, 1, 9, 0, 0, 0);
            cycle("saturate");
        end
        check("saturate.bubble_max", bubble_cnt_o, CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
